// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of one shared ALU result mux.
// One operation is in flight at a time; round-robin fairness is applied on response completion.
module alu_share_arb #(
    parameter logic [2:0]  MC_OPCODE = 3'b111,
    parameter int unsigned MC_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [2:0]  req0_op,
    input  logic [2:0]  req1_op,
    input  logic [11:0] req0_a,
    input  logic [11:0] req0_b,
    input  logic [11:0] req1_a,
    input  logic [11:0] req1_b,
    output logic [2:0]  alu_sel,
    output logic [11:0] alu_op1,
    output logic [11:0] alu_op2,
    input  logic [11:0] alu_result,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [11:0] rsp_data,
    input  logic        rsp_ready
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 1);

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  sel_q, sel_d;
    logic [11:0] op1_q, op1_d;
    logic [11:0] op2_q, op2_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [11:0] rsp_data_q, rsp_data_d;

    logic        gnt_any;
    logic        gnt1;
    logic [2:0]  gnt_op;

    // Requester 1 wins when it is alone or when the pointer favours it.
    assign gnt_any = req0_valid | req1_valid;
    assign gnt1    = req1_valid & (~req0_valid | rr_q);
    assign gnt_op  = gnt1 ? req1_op : req0_op;

    assign req0_ready = rst_n & (state_q == IDLE) & gnt_any & ~gnt1;
    assign req1_ready = rst_n & (state_q == IDLE) & gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            cnt_q       <= 4'd0;
            sel_q       <= 3'b000;
            op1_q       <= 12'd0;
            op2_q       <= 12'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 12'd0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    sel_d    = gnt_op;
                    op1_d    = gnt1 ? req1_a : req0_a;
                    op2_d    = gnt1 ? req1_b : req0_b;
                    rsp_id_d = gnt1;
                    cnt_d    = (gnt_op == MC_OPCODE) ? MC_LOAD : 4'd0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_data_d  = alu_result;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_d        = ~rsp_id_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_sel   = sel_q;
    assign alu_op1   = op1_q;
    assign alu_op2   = op2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 SHALL have parameter MC_OPCODE, default 3'b111, meaning the opcode that is treated as multi-cycle.
REQ-002 SHALL have parameter MC_CYCLES, default 4, meaning the execute cycles for MC_OPCODE; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  requester n operation accepted this cycle.
REQ-007 SHALL have ports req0_op / req1_op  input  3  ALU function select for requester n.
REQ-008 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  12  operands for requester n.
REQ-009 SHALL have port alu_sel  output  3  function select to the shared 8:1 result mux.
REQ-010 SHALL have ports alu_op1 / alu_op2  output  12  operands to the shared ALU.
REQ-011 SHALL have port alu_result  input  12  shared mux output, combinational from alu_sel/op1/op2.
REQ-012 SHALL have port rsp_valid  output  1  result available.
REQ-013 SHALL have port rsp_id  output  1  requester index owning the result.
REQ-014 SHALL have port rsp_data  output  12  captured result.
REQ-015 SHALL have port rsp_ready  input  1  consumer takes the result.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-017 SHALL, in IDLE, grant one valid requester: if exactly one is valid, it is granted; if both are valid, the requester equal to the round-robin pointer rr is granted.
REQ-018 SHALL assert reqN_ready combinationally only in IDLE and only for the granted requester; at most one ready is high per cycle.
REQ-019 SHALL, on the accepting cycle (valid && ready), register op/a/b into alu_sel/alu_op1/alu_op2, record the grant index as rsp_id, and enter EXEC.
REQ-020 SHALL load a 4-bit down-counter on acceptance with MC_CYCLES-1 if op == MC_OPCODE, else 0.
REQ-021 SHALL, in EXEC with counter != 0, decrement the counter and keep alu_sel/op1/op2 stable.
REQ-022 SHALL, in EXEC with counter == 0, capture alu_result into rsp_data, set rsp_valid, and enter RESP; single-cycle latency is accept edge to rsp_valid = 2 edges, and MC latency is MC_CYCLES+1 edges.
REQ-023 SHALL, in RESP, hold rsp_valid/rsp_id/rsp_data stable until rsp_ready is high; on that edge it SHALL clear rsp_valid, set rr to the complement of rsp_id, and return to IDLE.
REQ-024 SHALL NOT accept a new request in EXEC or RESP; the minimum issue interval is 3 cycles for single-cycle ops.
REQ-025 SHALL update rr only on response completion; a requester deasserting valid before grant is not served and does not affect rr.
REQ-026 SHALL hold alu_sel/alu_op1/alu_op2 at their last accepted values in IDLE (no glitching to zero between ops).
REQ-027 SHALL accept rsp_ready held high continuously, completing RESP in exactly one cycle.
REQ-028 SHALL ignore rsp_ready outside RESP.

Reset
REQ-029 SHALL, while rst_n is low, force state=IDLE, rr=0, counter=0, alu_sel=3'b000, alu_op1=alu_op2=0, rsp_valid=0, rsp_id=0, and rsp_data=0; reqN_ready SHALL then be 0.
REQ-030 SHALL, on assertion of rst_n mid-EXEC or mid-RESP, discard the in-flight operation with no response issued; operation resumes in IDLE on the first edge after deassertion.

Verification
REQ-031 SHALL cover: req0 only, op=3'b001, a=12'h00F, b=12'h001, rsp_ready=1 -> req0_ready for 1 cycle; rsp_valid 2 edges later with rsp_id=0 and rsp_data equal to alu_result for sel 001.
REQ-032 SHALL cover: both valid from reset -> req0 served first, then req1; with both still valid, grants alternate 0,1,0,1 over 4 ops.
REQ-033 SHALL cover: req1 op=MC_OPCODE, MC_CYCLES=4 -> alu_sel/op1/op2 stable for 4 EXEC cycles; rsp_valid at accept+5 edges with rsp_id=1.
REQ-034 SHALL cover: rsp_ready held low 6 cycles in RESP -> rsp_valid/rsp_data constant, both readies 0; release -> IDLE next edge.
REQ-035 SHALL cover: rst_n pulsed low during the 2nd MC EXEC cycle -> all outputs equal reset values, no rsp_valid, and rr=0 afterwards.
REQ-036 SHALL cover: op=3'b000 with a=b=12'hFFF -> rsp_data=12'h000.
